// File: rtl/fifo_pkg.sv
// Shared defaults and the address-width helper for the parametrised FIFO.
package fifo_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 8;

  // Smallest r with 2**r >= n; used at elaboration time to size pointers.
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_read_mux.sv
// DEPTH-to-1 combinational word selector feeding the FIFO output register.
module fifo_read_mux
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = clog2_f(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] i_words,
  input  logic [AW-1:0]               i_sel,
  output logic [WIDTH-1:0]            o_word
);

  assign o_word = i_words[i_sel];

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO with registered read data and per-request ack/err pulses.
// Storage is a register array addressed by wrapping write/read pointers.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  DEPTH = DEF_DEPTH,
  localparam int AW    = clog2_f(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             full,
  output logic             empty,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             rd_ack,
  output logic             rd_err,
  output logic [AW:0]      data_count
);

  // Request/response contract: a request (we or re) is sampled at a rising
  // edge and always answered one cycle later by exactly one of ack or err.
  // A read may free the slot a same-cycle write needs, so a write into a
  // full FIFO is accepted when the read is accepted; a read from an empty
  // FIFO is never satisfied by the word being written in that cycle.

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0]               r_wp;
  logic [AW-1:0]               r_rp;
  logic [AW:0]                 r_count;
  logic [WIDTH-1:0]            r_dout;
  logic                        r_wr_ack;
  logic                        r_wr_err;
  logic                        r_rd_ack;
  logic                        r_rd_err;

  logic                        w_full;
  logic                        w_empty;
  logic                        w_rd_ok;
  logic                        w_wr_ok;
  logic [WIDTH-1:0]            w_rd_word;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_rd_ok = re && !w_empty;
  assign w_wr_ok = we && (!w_full || w_rd_ok);

  fifo_read_mux #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_read_mux (
    .i_words (r_mem),
    .i_sel   (r_rp),
    .o_word  (w_rd_word)
  );

  // Memory is never cleared; reset only discards its contents logically.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_ok) r_mem[r_wp] <= d_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_wr_ack <= 1'b0;
      r_wr_err <= 1'b0;
      r_rd_ack <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      if (w_wr_ok) r_wp <= r_wp + AW'(1);
      if (w_rd_ok) begin
        r_rp   <= r_rp + AW'(1);
        r_dout <= w_rd_word;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      r_wr_ack <= w_wr_ok;
      r_wr_err <= we && !w_wr_ok;
      r_rd_ack <= w_rd_ok;
      r_rd_err <= re && !w_rd_ok;
    end
  end

  assign d_out      = r_dout;
  assign full       = w_full;
  assign empty      = w_empty;
  assign wr_ack     = r_wr_ack;
  assign wr_err     = r_wr_err;
  assign rd_ack     = r_rd_ack;
  assign rd_err     = r_rd_err;
  assign data_count = r_count;

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 8: number of entries; SHALL be a power of two, >= 2.
REQ-003 Derived constant AW = log2(DEPTH): address width; count width is AW+1.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 we  input  1  write request.
REQ-007 re  input  1  read request.
REQ-008 d_in  input  WIDTH  write data.
REQ-009 d_out  output  WIDTH  registered read data.
REQ-010 full  output  1  high when count == DEPTH.
REQ-011 empty  output  1  high when count == 0.
REQ-012 wr_ack  output  1  one-cycle pulse: previous-cycle write accepted.
REQ-013 wr_err  output  1  one-cycle pulse: previous-cycle write rejected.
REQ-014 rd_ack  output  1  one-cycle pulse: previous-cycle read accepted.
REQ-015 rd_err  output  1  one-cycle pulse: previous-cycle read rejected.
REQ-016 data_count  output  AW+1  current occupancy, 0..DEPTH.

Function
REQ-017 Storage: DEPTH x WIDTH register array; write pointer wp and read pointer rp, each AW bits, wrap modulo DEPTH.
REQ-018 Accept rules, evaluated on pre-edge state: read accepted iff re && !empty; write accepted iff we && (!full || read accepted).
REQ-019 Accepted write: mem[wp] <= d_in, wp <= wp+1 on the same edge.
REQ-020 Accepted read: d_out <= mem[rp], rp <= rp+1; d_out valid in the cycle after re is sampled (latency 1), coincident with rd_ack.
REQ-021 No accepted read: d_out SHALL hold its previous value (never X).
REQ-022 Count: +1 on write only, -1 on read only, unchanged on both or neither; full/empty decoded combinationally from count.
REQ-023 Full with simultaneous we && re: both accepted, count stays DEPTH, read returns the oldest entry, never the word being written.
REQ-024 Empty with simultaneous we && re: write accepted, read rejected (rd_err=1), count becomes 1; no bypass of d_in to d_out.
REQ-025 Rejected write: memory, wp, count unchanged; wr_err pulses. Rejected read: d_out, rp, count unchanged; rd_err pulses.
REQ-026 Ack/err flags are registered; each is high exactly one cycle per request cycle; wr_ack and wr_err never both high; rd_ack and rd_err never both high.
REQ-027 Pointer wrap-around SHALL be seamless: ordering preserved across any number of wraps.

Reset
REQ-028 On reset high at a clock edge: wp=0, rp=0, count=0, d_out=0, all ack/err=0; empty=1, full=0 from the following cycle.
REQ-029 Reset takes priority over we/re in the same cycle; requests in that cycle are neither acknowledged nor errored.
REQ-030 Memory contents are not cleared; reset mid-operation discards all stored words logically.

Structure
REQ-031 Shared package fifo_pkg holds default WIDTH/DEPTH constants and the log2 helper used to derive AW.
REQ-032 Read selection is a single sub-module fifo_read_mux: parametrised DEPTH-to-1 mux of WIDTH-bit words, select = rp, combinational; d_out register lives in param_fifo.
REQ-033 Status/count logic and pointer logic reside in param_fifo; no other sub-modules.

Verification (WIDTH=32, DEPTH=8 unless stated)
REQ-034 Reset, then re=1 one cycle -> next cycle rd_err=1, rd_ack=0, d_out=0, empty=1, data_count=0.
REQ-035 Write 0x11..0x88 (8 cycles) then we=1 with 0x99 -> full=1, data_count=8, wr_ack on first 8, wr_err on 9th; reading 8 returns 0x11..0x88 in order.
REQ-036 Full, we=re=1 with d_in=0xAA -> rd_ack=wr_ack=1, d_out=0x11, data_count=8; subsequent drain ends with 0xAA.
REQ-037 Empty, we=re=1 with d_in=0x55 -> wr_ack=1, rd_err=1, data_count=1, d_out unchanged; next read returns 0x55.
REQ-038 20 interleaved writes/reads of incrementing values (pointers wrap twice) -> read sequence strictly incrementing, no loss or duplication.
REQ-039 Write 3 words, assert reset with we=re=1 -> next cycle count=0, empty=1, all ack/err=0, d_out=0; DEPTH=4 and WIDTH=8 re-run of REQ-035 passes.
